rom_arbiter: RTL and testbench

//  Shares the single combinational read port of the program ROM between two

---
 rtl/rom_arb_pkg.sv | 23 ++
 rtl/rom_arbiter_if.sv | 50 +++++
 rtl/rom_rsp_slot.sv | 68 ++++++
 rtl/rom_arbiter.sv | 89 ++++++++
 tb/tb_rom_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// ============================================================================
// Module  : rom_arb_pkg
// Brief   : Shared types and defaults for the program-ROM read-port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 32;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/rom_arbiter_if.sv
// ============================================================================
// Module  : rom_arbiter_if
// Brief   : Fetch/data requester handshakes plus the ROM read port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface rom_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 32
) ();

    logic          f_req;
    logic [AW-1:0] f_ad;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rd;
    logic          f_err;
    logic          f_rready;

    logic          d_req;
    logic [AW-1:0] d_ad;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rd;
    logic          d_err;
    logic          d_rready;

    logic [AW-1:0] mem_ad;
    logic [DW-1:0] mem_rd;

    // Arbiter side
    modport slave (
        input  f_req, f_ad, f_rready, d_req, d_ad, d_rready, mem_rd,
        output f_gnt, f_rvalid, f_rd, f_err,
        output d_gnt, d_rvalid, d_rd, d_err,
        output mem_ad
    );

    // Requesters and ROM side
    modport master (
        output f_req, f_ad, f_rready, d_req, d_ad, d_rready, mem_rd,
        input  f_gnt, f_rvalid, f_rd, f_err,
        input  d_gnt, d_rvalid, d_rd, d_err,
        input  mem_ad
    );

endinterface

`default_nettype wire

// File: rtl/rom_rsp_slot.sv
// ============================================================================
// Module  : rom_rsp_slot
// Brief   : One-entry registered response slot with rvalid/rready handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_rsp_slot
    import rom_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_rd,
    input  logic          load_err,
    input  logic          rready,
    output logic          full,
    output logic          rvalid,
    output logic [DW-1:0] rd,
    output logic          err
);

    slot_state_t   r_state;
    slot_state_t   w_state_nxt;
    logic [DW-1:0] r_rd;
    logic          r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load while FULL is a reload: old response consumed, new one captured.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (load) w_state_nxt = SLOT_FULL;
            SLOT_FULL: begin
                if (load)        w_state_nxt = SLOT_FULL;
                else if (rready) w_state_nxt = SLOT_EMPTY;
            end
            default:             w_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd  <= '0;
            r_err <= 1'b0;
        end else if (load) begin
            r_rd  <= load_rd;
            r_err <= load_err;
        end
    end

    assign full   = (r_state == SLOT_FULL);
    assign rvalid = (r_state == SLOT_FULL);
    assign rd     = r_rd;
    assign err    = r_err;

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module  : rom_arbiter
// Brief   : Shares the program ROM read port between fetch and data requesters.
//           ARB_RR_EN defined -> round-robin; undefined -> fetch has priority.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_arbiter_if.slave bus
);

    logic          w_f_full;
    logic          w_d_full;
    logic          w_f_elig;
    logic          w_d_elig;
    logic          w_pick_d;
    logic          w_f_gnt;
    logic          w_d_gnt;
    logic [AW-1:0] w_mem_ad;
    logic          w_mem_err;

    // A full slot can still accept when its consumer drains it this cycle.
    assign w_f_elig = bus.f_req && (!w_f_full || bus.f_rready);
    assign w_d_elig = bus.d_req && (!w_d_full || bus.d_rready);

`ifdef ARB_RR_EN
    logic r_last;

    assign w_pick_d = w_d_elig && (!w_f_elig || (r_last == PORT_F));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_D;
        end else if (w_f_gnt) begin
            r_last <= PORT_F;
        end else if (w_d_gnt) begin
            r_last <= PORT_D;
        end
    end
`else
    assign w_pick_d = w_d_elig && !w_f_elig;
`endif

    assign w_d_gnt   = rst_n && w_pick_d;
    assign w_f_gnt   = rst_n && w_f_elig && !w_pick_d;
    assign w_mem_ad  = w_d_gnt ? bus.d_ad : bus.f_ad;
    assign w_mem_err = |w_mem_ad[1:0];

    assign bus.f_gnt  = w_f_gnt;
    assign bus.d_gnt  = w_d_gnt;
    assign bus.mem_ad = w_mem_ad;

    rom_rsp_slot #(.DW(DW)) u_f_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_f_gnt),
        .load_rd  (bus.mem_rd),
        .load_err (w_mem_err),
        .rready   (bus.f_rready),
        .full     (w_f_full),
        .rvalid   (bus.f_rvalid),
        .rd       (bus.f_rd),
        .err      (bus.f_err)
    );

    rom_rsp_slot #(.DW(DW)) u_d_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_d_gnt),
        .load_rd  (bus.mem_rd),
        .load_err (w_mem_err),
        .rready   (bus.d_rready),
        .full     (w_d_full),
        .rvalid   (bus.d_rvalid),
        .rd       (bus.d_rd),
        .err      (bus.d_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module  : tb_rom_arbiter
// Brief   : Directed table-driven bench for rom_arbiter (honours ARB_RR_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    rom_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    rom_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM word i holds A000_0000 + i
    assign bus.mem_rd = 32'hA000_0000 + {28'd0, bus.mem_ad[5:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        f_req;
        logic [5:0]  f_ad;
        logic        f_rready;
        logic        d_req;
        logic [5:0]  d_ad;
        logic        d_rready;
        logic        f_gnt;
        logic        d_gnt;
        logic [5:0]  mem_ad;
        logic        f_rvalid;
        logic [31:0] f_rd;
        logic        f_err;
        logic        d_rvalid;
        logic [31:0] d_rd;
        logic        d_err;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fr, input logic [5:0] fa, input logic frr,
                         input logic dr, input logic [5:0] da, input logic drr);
        bus.f_req    = fr;
        bus.f_ad     = fa;
        bus.f_rready = frr;
        bus.d_req    = dr;
        bus.d_ad     = da;
        bus.d_rready = drr;
    endtask

    // Both requesters contend each cycle; checks winner, mem_ad and the response.
    task automatic contend(input logic exp_d, input string tag);
        drive(1'b1, 6'h10, 1'b1, 1'b1, 6'h20, 1'b1);
        @(negedge clk);
        chk({tag, " f_gnt"}, {31'd0, bus.f_gnt}, {31'd0, !exp_d});
        chk({tag, " d_gnt"}, {31'd0, bus.d_gnt}, {31'd0, exp_d});
        chk({tag, " mem_ad"}, {26'd0, bus.mem_ad}, exp_d ? 32'h20 : 32'h10);
        @(posedge clk); #1;
        chk({tag, " f_rvalid"}, {31'd0, bus.f_rvalid}, {31'd0, !exp_d});
        chk({tag, " d_rvalid"}, {31'd0, bus.d_rvalid}, {31'd0, exp_d});
        if (exp_d) chk({tag, " d_rd"}, bus.d_rd, 32'hA000_0008);
        else       chk({tag, " f_rd"}, bus.f_rd, 32'hA000_0004);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d;
        n_vec = 0;
        n_err = 0;

        tbl[0] = '{1'b0, 6'h08, 1'b1, 1'b0, 6'h10, 1'b1, 1'b0, 1'b0, 6'h08,
                   1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 6'h04, 1'b1, 1'b0, 6'h10, 1'b1, 1'b1, 1'b0, 6'h04,
                   1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 6'h04, 1'b1, 1'b0, 6'h10, 1'b1, 1'b0, 1'b0, 6'h04,
                   1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        tbl[3] = '{1'b0, 6'h04, 1'b1, 1'b1, 6'h05, 1'b1, 1'b0, 1'b1, 6'h05,
                   1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0001, 1'b1};
        tbl[4] = '{1'b0, 6'h04, 1'b1, 1'b1, 6'h3C, 1'b1, 1'b0, 1'b1, 6'h3C,
                   1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_000F, 1'b0};
        tbl[5] = '{1'b1, 6'h0A, 1'b1, 1'b0, 6'h3C, 1'b1, 1'b1, 1'b0, 6'h0A,
                   1'b1, 32'hA000_0002, 1'b1, 1'b0, 32'h0, 1'b0};
        tbl[6] = '{1'b0, 6'h0A, 1'b1, 1'b0, 6'h3C, 1'b1, 1'b0, 1'b0, 6'h0A,
                   1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};

        // Reset: requests held high must not be granted
        rst_n = 1'b0;
        drive(1'b1, 6'h04, 1'b1, 1'b1, 6'h08, 1'b1);
        #2;
        chk("rst f_gnt", {31'd0, bus.f_gnt}, 32'd0);
        chk("rst d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        chk("rst f_rvalid", {31'd0, bus.f_rvalid}, 32'd0);
        chk("rst d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
        chk("rst f_rd", bus.f_rd, 32'd0);
        chk("rst d_rd", bus.d_rd, 32'd0);
        chk("rst f_err", {31'd0, bus.f_err}, 32'd0);
        chk("rst d_err", {31'd0, bus.d_err}, 32'd0);
        drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].f_req, tbl[i].f_ad, tbl[i].f_rready,
                  tbl[i].d_req, tbl[i].d_ad, tbl[i].d_rready);
            @(negedge clk);
            chk($sformatf("v%0d f_gnt", i), {31'd0, bus.f_gnt}, {31'd0, tbl[i].f_gnt});
            chk($sformatf("v%0d d_gnt", i), {31'd0, bus.d_gnt}, {31'd0, tbl[i].d_gnt});
            chk($sformatf("v%0d mem_ad", i), {26'd0, bus.mem_ad}, {26'd0, tbl[i].mem_ad});
            @(posedge clk); #1;
            chk($sformatf("v%0d f_rvalid", i), {31'd0, bus.f_rvalid}, {31'd0, tbl[i].f_rvalid});
            chk($sformatf("v%0d d_rvalid", i), {31'd0, bus.d_rvalid}, {31'd0, tbl[i].d_rvalid});
            if (tbl[i].f_rvalid) begin
                chk($sformatf("v%0d f_rd", i), bus.f_rd, tbl[i].f_rd);
                chk($sformatf("v%0d f_err", i), {31'd0, bus.f_err}, {31'd0, tbl[i].f_err});
            end
            if (tbl[i].d_rvalid) begin
                chk($sformatf("v%0d d_rd", i), bus.d_rd, tbl[i].d_rd);
                chk($sformatf("v%0d d_err", i), {31'd0, bus.d_err}, {31'd0, tbl[i].d_err});
            end
        end

        // Contention: last grant was F, so round-robin starts with D
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b0;
`endif
            contend(exp_d, $sformatf("arb%0d", k));
        end

        // Backpressure: pending fetch response holds, new request stalls
        drive(1'b1, 6'h04, 1'b1, 1'b0, 6'h00, 1'b1);
        @(posedge clk); #1;
        chk("bp load f_rd", bus.f_rd, 32'hA000_0001);
        drive(1'b1, 6'h0C, 1'b0, 1'b0, 6'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d f_gnt", k), {31'd0, bus.f_gnt}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d f_rvalid", k), {31'd0, bus.f_rvalid}, 32'd1);
            chk($sformatf("bp%0d f_rd", k), bus.f_rd, 32'hA000_0001);
        end
        bus.f_rready = 1'b1;
        @(negedge clk);
        chk("bp release f_gnt", {31'd0, bus.f_gnt}, 32'd1);
        @(posedge clk); #1;
        chk("bp release f_rvalid", {31'd0, bus.f_rvalid}, 32'd1);
        chk("bp release f_rd", bus.f_rd, 32'hA000_0003);

        // Fill both slots, then reset asynchronously mid-cycle
        drive(1'b1, 6'h04, 1'b0, 1'b0, 6'h00, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 6'h04, 1'b0, 1'b1, 6'h08, 1'b0);
        @(posedge clk); #1;
        chk("full f_rvalid", {31'd0, bus.f_rvalid}, 32'd1);
        chk("full d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
        drive(1'b1, 6'h04, 1'b1, 1'b1, 6'h08, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async f_rvalid", {31'd0, bus.f_rvalid}, 32'd0);
        chk("async d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
        chk("async f_rd", bus.f_rd, 32'd0);
        chk("async d_rd", bus.d_rd, 32'd0);
        chk("async f_gnt", {31'd0, bus.f_gnt}, 32'd0);
        chk("async d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("post-rst%0d f_rvalid", k), {31'd0, bus.f_rvalid}, 32'd0);
            chk($sformatf("post-rst%0d d_rvalid", k), {31'd0, bus.d_rvalid}, 32'd0);
        end

        // After reset F wins the first conflict in either mode
        for (int k = 0; k < 2; k++) begin
`ifdef ARB_RR_EN
            exp_d = (k % 2 == 1);
`else
            exp_d = 1'b0;
`endif
            contend(exp_d, $sformatf("rst-arb%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
